// File: rtl/arbitro_jogadores_if.sv
// Buzzer arbiter bus: round control and button inputs toward the arbiter,
// grant/winner/lockout reporting back toward the game control unit.
interface arbitro_jogadores_if #(
  parameter int N_JOG = 4,
  parameter int L_BOT = 4,
  parameter int W_ID  = $clog2(N_JOG)
);
  logic                     inicia_rodada;
  logic                     habilita;
  logic                     reabre;
  logic [N_JOG*L_BOT-1:0]   botoes;
  logic                     fez_jogada;
  logic [L_BOT-1:0]         jogada;
  logic [W_ID-1:0]          vencedor;
  logic                     vencedor_valido;
  logic [N_JOG-1:0]         bloqueados;
  logic                     queimou;
  logic                     todos_bloqueados;
  logic [3:0]               db_estado;

  // Control-unit side: drives the round and the buttons, watches the result
  modport master (
    output inicia_rodada, habilita, reabre, botoes,
    input  fez_jogada, jogada, vencedor, vencedor_valido,
           bloqueados, queimou, todos_bloqueados, db_estado
  );

  // Arbiter side
  modport slave (
    input  inicia_rodada, habilita, reabre, botoes,
    output fez_jogada, jogada, vencedor, vencedor_valido,
           bloqueados, queimou, todos_bloqueados, db_estado
  );
endinterface

// File: rtl/arbitro_jogadores.sv
// Multi-player buzzer arbiter. Grants the single answer slot to the first
// fresh press inside the answer window, breaks ties round-robin, and locks
// out players who press before the window opens or who already answered.
module arbitro_jogadores #(
  parameter int N_JOG = 4,
  parameter int L_BOT = 4,
  parameter int W_ID  = $clog2(N_JOG)
) (
  input logic                clock,
  input logic                reset,
  arbitro_jogadores_if.slave bus
);

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    ARMADO    = 4'd1,
    DISPUTA   = 4'd2,
    CONCEDIDO = 4'd3
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [W_ID-1:0]    ponteiro_q, ponteiro_d;
  logic [N_JOG-1:0]   anterior_q, anterior_d;
  logic [N_JOG-1:0]   bloqueados_q, bloqueados_d;
  logic               vencedor_valido_q, vencedor_valido_d;
  logic [W_ID-1:0]    vencedor_q, vencedor_d;
  logic [L_BOT-1:0]   jogada_q, jogada_d;
  logic               fez_jogada_q, fez_jogada_d;
  logic               queimou_q, queimou_d;

  logic [N_JOG-1:0]   nivel;
  logic [N_JOG-1:0]   ed;
  logic [N_JOG-1:0]   candidatos;
  logic               achou;
  logic [W_ID-1:0]    escolhido;
  logic [W_ID-1:0]    proximo;
  logic [L_BOT-1:0]   jogada_escolhida;

  // Per-player press level and rising edge; a held button yields only one edge
  always_comb begin
    nivel = '0;
    for (int p = 0; p < N_JOG; p++) begin
      nivel[p] = |bus.botoes[p*L_BOT +: L_BOT];
    end
    ed         = nivel & ~anterior_q;
    anterior_d = nivel;
  end

  // Round-robin pick among eligible edges, scanning from the fairness pointer
  always_comb begin
    int idx;
    int sel;
    candidatos = ed & ~bloqueados_q;
    achou      = 1'b0;
    sel        = 0;
    for (int i = 0; i < N_JOG; i++) begin
      idx = int'(ponteiro_q) + i;
      if (idx >= N_JOG) begin
        idx = idx - N_JOG;
      end
      if (!achou && candidatos[idx]) begin
        achou = 1'b1;
        sel   = idx;
      end
    end
    escolhido        = W_ID'(sel);
    proximo          = (sel == N_JOG - 1) ? '0 : W_ID'(sel + 1);
    jogada_escolhida = bus.botoes[sel*L_BOT +: L_BOT];
  end

  // Round FSM: new-round pulse overrides everything, then per-state handling
  always_comb begin
    estado_d          = estado_q;
    ponteiro_d        = ponteiro_q;
    bloqueados_d      = bloqueados_q;
    vencedor_valido_d = vencedor_valido_q;
    vencedor_d        = vencedor_q;
    jogada_d          = jogada_q;
    fez_jogada_d      = 1'b0;
    queimou_d         = 1'b0;

    if (bus.inicia_rodada) begin
      estado_d          = ARMADO;
      bloqueados_d      = '0;
      vencedor_valido_d = 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          estado_d = OCIOSO;
        end
        ARMADO: begin
          if (|ed) begin
            bloqueados_d = bloqueados_q | ed;
            queimou_d    = 1'b1;
          end
          if (bus.habilita) begin
            estado_d = DISPUTA;
          end
        end
        DISPUTA: begin
          if (achou) begin
            vencedor_d              = escolhido;
            jogada_d                = jogada_escolhida;
            fez_jogada_d            = 1'b1;
            vencedor_valido_d       = 1'b1;
            bloqueados_d[escolhido] = 1'b1;
            ponteiro_d              = proximo;
            estado_d                = CONCEDIDO;
          end else if (!bus.habilita) begin
            estado_d = OCIOSO;
          end
        end
        CONCEDIDO: begin
          if (bus.reabre) begin
            vencedor_valido_d = 1'b0;
            estado_d          = bus.habilita ? DISPUTA : OCIOSO;
          end
        end
        default: begin
          estado_d = OCIOSO;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by the active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q          <= OCIOSO;
      ponteiro_q        <= '0;
      anterior_q        <= '0;
      bloqueados_q      <= '0;
      vencedor_valido_q <= 1'b0;
      vencedor_q        <= '0;
      jogada_q          <= '0;
      fez_jogada_q      <= 1'b0;
      queimou_q         <= 1'b0;
    end else begin
      estado_q          <= estado_d;
      ponteiro_q        <= ponteiro_d;
      anterior_q        <= anterior_d;
      bloqueados_q      <= bloqueados_d;
      vencedor_valido_q <= vencedor_valido_d;
      vencedor_q        <= vencedor_d;
      jogada_q          <= jogada_d;
      fez_jogada_q      <= fez_jogada_d;
      queimou_q         <= queimou_d;
    end
  end

  assign bus.fez_jogada       = fez_jogada_q;
  assign bus.jogada           = jogada_q;
  assign bus.vencedor         = vencedor_q;
  assign bus.vencedor_valido  = vencedor_valido_q;
  assign bus.bloqueados       = bloqueados_q;
  assign bus.queimou          = queimou_q;
  assign bus.todos_bloqueados = &bloqueados_q;
  assign bus.db_estado        = estado_q;

endmodule
